// File: rtl/rnd_instr_unit.sv
// rnd_instr_unit: executes a CXNN-style random operation (VX = random AND NN)
// and keeps a running health check on the incoming PRNG byte stream.
// The random byte sampled is the one present in the cycle after acceptance,
// so the result is decoupled from the instruction fetch timing.
module rnd_instr_unit #(
  parameter int STUCK_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rnd_byte,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_x,
  input  logic [7:0] req_nn,
  output logic       wr_en,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ack,
  output logic       done,
  output logic       stuck
);

  // Counter is wide enough to hold STUCK_LIMIT itself, so saturation never wraps.
  localparam int CNT_W = (STUCK_LIMIT < 2) ? 1 : $clog2(STUCK_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STUCK_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       lat_x;
  logic [7:0]       lat_nn;

  logic [7:0]       prev_byte;
  logic             prev_valid;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_next;

  // Only the idle state can take a new request; reset forces IDLE so this reads 1 during reset.
  assign req_ready = (state == IDLE);

  // Operation sequencer: accept, sample the PRNG one cycle later, then hold the write until acked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat_x   <= 4'h0;
      lat_nn  <= 8'h00;
      wr_en   <= 1'b0;
      wr_addr <= 4'h0;
      wr_data <= 8'h00;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_x  <= req_x;
            lat_nn <= req_nn;
            state  <= SAMPLE;
          end
        end
        SAMPLE: begin
          wr_data <= rnd_byte & lat_nn;
          wr_addr <= lat_x;
          wr_en   <= 1'b1;
          state   <= WRITE;
        end
        WRITE: begin
          if (wr_ack) begin
            wr_en <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          wr_en <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Next run length: grows on a repeated byte (saturating), restarts on any change.
  always_comb begin
    run_next = '0;
    if (prev_valid && (rnd_byte == prev_byte)) begin
      if (run_cnt == LIMIT) begin
        run_next = run_cnt;
      end else begin
        run_next = run_cnt + CNT_W'(1);
      end
    end
  end

  // Health monitor runs every cycle regardless of the sequencer; the alarm is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_byte  <= 8'h00;
      prev_valid <= 1'b0;
      run_cnt    <= '0;
      stuck      <= 1'b0;
    end else begin
      prev_byte  <= rnd_byte;
      prev_valid <= 1'b1;
      run_cnt    <= run_next;
      if (run_next == LIMIT) begin
        stuck <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rnd_instr_unit.md
RND_INSTR_UNIT -- requirements
Module: rnd_instr_unit

Interface
REQ-001 SHALL have parameter: STUCK_LIMIT, default 8, number of consecutive identical random samples that flags a stuck generator.
REQ-002 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: rnd_byte  input  8  free-running random byte from the PRNG, new value every clock.
REQ-005 SHALL have port: req_valid  input  1  CPU requests a CXNN random operation.
REQ-006 SHALL have port: req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port: req_x  input  4  destination register index VX.
REQ-008 SHALL have port: req_nn  input  8  mask byte NN.
REQ-009 SHALL have port: wr_en  output  1  register-file write request.
REQ-010 SHALL have port: wr_addr  output  4  register-file write index.
REQ-011 SHALL have port: wr_data  output  8  register-file write data.
REQ-012 SHALL have port: wr_ack  input  1  register file accepted the write this cycle.
REQ-013 SHALL have port: done  output  1  one-cycle completion pulse to CPU.
REQ-014 SHALL have port: stuck  output  1  sticky PRNG health alarm.

Function
REQ-015 SHALL implement FSM states IDLE, SAMPLE, WRITE; req_ready = 1 only in IDLE.
REQ-016 IDLE: on edge with req_valid=1 and req_ready=1, SHALL latch req_x and req_nn, go to SAMPLE; req_valid=0 -> stay IDLE.
REQ-017 SAMPLE: lasts exactly one cycle; at its closing edge SHALL latch wr_data = rnd_byte AND latched nn (rnd_byte value present during SAMPLE, not acceptance cycle), go to WRITE.
REQ-018 WRITE: wr_en=1, wr_addr=latched x, wr_data held stable every cycle until wr_ack sampled 1.
REQ-019 wr_ack=1 in first WRITE cycle SHALL be honoured (zero-wait write); wr_ack while wr_en=0 SHALL be ignored.
REQ-020 On edge with WRITE and wr_ack=1: SHALL go to IDLE, deassert wr_en, assert registered done for exactly one cycle.
REQ-021 Latency: request accepted at edge k -> wr_en high after edge k+1 -> with immediate ack, done high after edge k+2.
REQ-022 A new request SHALL be acceptable in the same cycle done is high (back-to-back throughput one op per 3 cycles).
REQ-023 req_x/req_nn changes after acceptance SHALL not affect the operation in progress.
REQ-024 req_nn=0x00 SHALL still perform the write with wr_data=0x00.
REQ-025 Health monitor SHALL run every cycle independent of FSM: register previous rnd_byte and a prev_valid flag (0 after reset, 1 after first sample).
REQ-026 When prev_valid=1 and rnd_byte == previous, run counter SHALL increment, saturating at STUCK_LIMIT; any difference SHALL clear it to 0.
REQ-027 stuck SHALL set when run counter reaches STUCK_LIMIT and remain 1 until reset; stuck SHALL not block operation.
REQ-028 Counter width SHALL hold STUCK_LIMIT without wrap; no overflow at saturation.

Reset
REQ-029 rst_n=0 SHALL immediately (asynchronously) force state IDLE, wr_en=0, wr_addr=0, wr_data=0, done=0, stuck=0, run counter=0, prev_valid=0, previous byte=0.
REQ-030 req_ready SHALL read 1 during and after reset; requests SHALL be ignored while rst_n=0.
REQ-031 Reset asserted mid-SAMPLE or mid-WRITE SHALL abort the operation: no write, no done pulse after release.
REQ-032 First accepting edge SHALL be the first rising clk edge after rst_n deasserts.

Verification
REQ-033 Basic op: req x=0x3, nn=0x0F, rnd_byte=0xA7 during SAMPLE, wr_ack tied 1 -> wr_en one cycle, wr_addr=0x3, wr_data=0x07, done pulse 1 cycle, latency per REQ-021.
REQ-034 Back-pressure: nn=0xFF, rnd_byte=0x5C, wr_ack low 4 cycles then high -> wr_en/wr_addr/wr_data=0x5C stable 5 cycles, req_ready=0 throughout, single done.
REQ-035 Back-to-back: second request (x=0xF, nn=0xF0, rnd_byte=0x9B) held valid during done cycle -> accepted that edge, wr_data=0x90.
REQ-036 Stuck: rnd_byte held 0x42 for 9 cycles after reset with STUCK_LIMIT=8 -> stuck rises after the 9th sample, stays 1 after rnd_byte varies; rnd_byte held 8 cycles then changed -> stuck stays 0.
REQ-037 Reset mid-WRITE: assert rst_n=0 while wr_en=1, wr_ack=0 -> wr_en, done drop without clock edge; after release, no done, req_ready=1.
REQ-038 Mask zero: nn=0x00, rnd_byte=0xFF -> write occurs, wr_data=0x00, done pulses.
